po2_mac_scheduler: RTL and testbench

PO2_MAC_SCHEDULER -- requirements
Module: po2_mac_scheduler

---
 rtl/po2_pkg.sv | 15 +
 rtl/po2_shift_unit.sv | 20 ++
 rtl/po2_mac_scheduler.sv | 77 +++++++
 tb/tb_po2_mac_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/po2_pkg.sv
// po2_pkg: shared state, weight and fixed-point padding definitions for the power-of-two MAC scheduler
package po2_pkg;
  localparam int LOG2_BITS = 8;
  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;
  typedef struct packed {
    logic                 negative;
    logic [LOG2_BITS-1:0] log2;
  } weight_t;
  function automatic int pad_msb(input int w, input int i);
    return i + 0 * w;
  endfunction
  function automatic int pad_lsb(input int w, input int i);
    return w - i;
  endfunction
endpackage

// File: rtl/po2_shift_unit.sv
// po2_shift_unit: widens a Q(I) sample to Q(2I) in 2W bits, applies the weight sign and 2^-log2 scaling
module po2_shift_unit import po2_pkg::*; #(
  parameter int W = 16,
  parameter int I = 4
) (
  input  logic [W-1:0]   sample,
  input  weight_t        weight,
  output logic [2*W-1:0] prod
);
  localparam int N = 2 * W;
  localparam int PM = pad_msb(W, I);
  localparam int PL = pad_lsb(W, I);
  logic signed [N-1:0] ext, val, shr;
  always_comb begin
    ext = {{PM{sample[W-1]}}, sample, {PL{1'b0}}};
    val = weight.negative ? -ext : ext;
    shr = val >>> weight.log2;
    prod = (32'(weight.log2) >= N - 1) ? {N{val[N-1]}} : shr;
  end
endmodule

// File: rtl/po2_mac_scheduler.sv
// po2_mac_scheduler: K-tap dot product with power-of-two weights, one tap per three cycles
module po2_mac_scheduler import po2_pkg::*; #(
  parameter int W  = 16,
  parameter int I  = 4,
  parameter int K  = 4,
  parameter int LW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 cfg_we,
  input  logic [$clog2(K)-1:0] cfg_addr,
  input  logic                 cfg_negative,
  input  logic [LW-1:0]        cfg_log2,
  output logic                 cfg_err,
  output logic [2*W-1:0]       out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int AW = $clog2(K);
  state_t state, state_nx;
  logic [AW-1:0] tap;
  logic [W-1:0] sample;
  logic [2*W-1:0] acc, prod, prod_nx;
  weight_t weights [K];
  logic last, cfg_ok;
  assign last = 32'(tap) == K - 1;
  assign cfg_ok = state == IDLE && tap == '0 && 32'(cfg_addr) < K;
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  assign out_data = acc;
  po2_shift_unit #(.W(W), .I(I)) u_shift (
    .sample(sample),
    .weight(weights[tap]),
    .prod  (prod_nx)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? MUL : IDLE;
      MUL:     state_nx = ACC;
      ACC:     state_nx = last ? OUT : IDLE;
      OUT:     state_nx = out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // a same-edge weight write lands before MUL reads the table, so tap 0 sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap <= '0;
      acc <= '0;
      prod <= '0;
      sample <= '0;
      cfg_err <= 1'b0;
      for (int k = 0; k < K; k++) weights[k] <= '0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) weights[cfg_addr] <= '{negative: cfg_negative, log2: LOG2_BITS'(cfg_log2)};
      if (in_valid && in_ready) sample <= in_data;
      if (state == MUL) prod <= prod_nx;
      if (state == ACC) begin
        acc <= acc + prod;
        if (!last) tap <= tap + AW'(1);
      end
      if (state == OUT && out_ready) begin
        acc <= '0;
        tap <= '0;
      end
    end
  end
endmodule

// File: tb/tb_po2_mac_scheduler.sv
// tb_po2_mac_scheduler: randomized and directed checks against a fixed-point arithmetic model
module tb_po2_mac_scheduler;
  logic clk = 0, rst_n = 0;
  logic [15:0] in_data = 0;
  logic in_valid = 0, in_ready, cfg_we = 0, cfg_negative = 0, cfg_err, out_valid, out_ready = 0;
  logic [1:0] cfg_addr = 0;
  logic [4:0] cfg_log2 = 0;
  logic [31:0] out_data;
  int n_chk = 0, n_pass = 0;
  bit mneg [4];
  int mlg [4];
  logic [31:0] macc = 0;
  int mtap = 0;

  po2_mac_scheduler #(.W(16), .I(4), .K(4), .LW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_negative(cfg_negative), .cfg_log2(cfg_log2),
    .cfg_err(cfg_err), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // weight = (-1)^neg * 2^-lg applied to the sample widened to 24 fractional bits
  function automatic logic [31:0] mprod(input logic [15:0] d, input bit ng, input int lg);
    longint x;
    x = longint'($signed(d)) * 4096;
    if (ng) x = -x;
    if (lg >= 31) x = (x < 0) ? -64'sd1 : 64'sd0;
    else x = x >>> lg;
    return x[31:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin mneg[k] = 0; mlg[k] = 0; end
    macc = 0;
    mtap = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [15:0] d, input bit wr, input int a, input bit ng, input int lg);
    bit ok;
    wait_ready();
    in_data = d;
    in_valid = 1;
    cfg_we = wr;
    cfg_addr = 2'(a);
    cfg_negative = ng;
    cfg_log2 = 5'(lg);
    @(posedge clk);
    ok = (mtap == 0);
    if (wr && ok) begin mneg[a] = ng; mlg[a] = lg; end
    macc = macc + mprod(d, mneg[mtap], mlg[mtap]);
    mtap++;
    @(negedge clk);
    in_valid = 0;
    cfg_we = 0;
    if (wr) check("cfg_err_send", cfg_err, !ok);
    check("busy_after_accept", in_ready, 0);
  endtask

  task automatic cfg_write(input int a, input bit ng, input int lg);
    bit ok;
    wait_ready();
    cfg_we = 1;
    cfg_addr = 2'(a);
    cfg_negative = ng;
    cfg_log2 = 5'(lg);
    @(posedge clk);
    ok = (mtap == 0);
    if (ok) begin mneg[a] = ng; mlg[a] = lg; end
    @(negedge clk);
    cfg_we = 0;
    check("cfg_err_idle", cfg_err, !ok);
  endtask

  task automatic bad_write(input int a, input bit ng, input int lg);
    cfg_we = 1;
    cfg_addr = 2'(a);
    cfg_negative = ng;
    cfg_log2 = 5'(lg);
    @(negedge clk);
    cfg_we = 0;
    check("cfg_err_pulse", cfg_err, 1);
    @(negedge clk);
    check("cfg_err_once", cfg_err, 0);
  endtask

  task automatic collect(input int stall, input logic [31:0] fixed, input bit use_fixed);
    check("lat_mul", out_valid, 0);
    @(negedge clk);
    check("lat_acc", out_valid, 0);
    @(negedge clk);
    check("lat_out", out_valid, 1);
    check("sum", out_data, macc);
    if (use_fixed) check("sum_fixed", out_data, fixed);
    repeat (stall) begin
      @(negedge clk);
      check("hold_data", out_data, macc);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("drop_valid", out_valid, 0);
    check("back_idle", in_ready, 1);
    macc = 0;
    mtap = 0;
  endtask

  initial begin
    bit quiet;
    #3;
    do_reset();
    cfg_write(0, 0, 0);
    cfg_write(1, 0, 1);
    cfg_write(2, 1, 1);
    cfg_write(3, 1, 2);
    repeat (4) send(16'h1000, 0, 0, 0, 0);
    collect(5, 32'h00C0_0000, 1);
    send(16'h1000, 0, 0, 0, 0);
    bad_write(0, 1, 7);
    repeat (3) send(16'h1000, 0, 0, 0, 0);
    collect(0, 32'h00C0_0000, 1);
    cfg_write(0, 1, 0);
    send(16'h8000, 0, 0, 0, 0);
    repeat (3) send(16'h0000, 0, 0, 0, 0);
    collect(1, 32'h0800_0000, 1);
    repeat (2) send(16'h1000, 0, 0, 0, 0);
    do_reset();
    quiet = 1;
    repeat (6) begin @(negedge clk); if (out_valid) quiet = 0; end
    check("no_valid_after_abort", quiet, 1);
    repeat (4) send(16'h1000, 0, 0, 0, 0);
    collect(0, 32'h0400_0000, 1);
    cfg_write(0, 0, 31);
    send(16'hF000, 0, 0, 0, 0);
    repeat (3) send(16'h0000, 0, 0, 0, 0);
    collect(0, 32'hFFFF_FFFF, 1);
    send(16'h1000, 1, 0, 1, 3);
    repeat (3) send(16'h0000, 0, 0, 0, 0);
    collect(0, 32'hFFE0_0000, 1);
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(1) == 1) cfg_write($urandom_range(3), 1'($urandom_range(1)), $urandom_range(31));
      for (int t = 0; t < 4; t++) begin
        send(16'($urandom), $urandom_range(3) == 0, $urandom_range(3), 1'($urandom_range(1)), $urandom_range(31));
        if (t < 3) begin
          case ($urandom_range(3))
            0: bad_write($urandom_range(3), 1'($urandom_range(1)), $urandom_range(31));
            1: cfg_write($urandom_range(3), 1'($urandom_range(1)), $urandom_range(31));
            default: ;
          endcase
        end
      end
      collect($urandom_range(3), 32'h0, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
